// File: rtl/sram_arbiter.sv
// sram_arbiter
//   Shares one SRAM controller port between two requesters:
//   port 0 is the neural-network trainer (nn_*), and port 1 is the
//   calibrator/logger (cal_*).
//   Each requester issues one read or write at a time over a valid/ready
//   handshake. Grants alternate round-robin when both ports are waiting.
//   The arbiter then holds the memory strobe for a fixed number of cycles,
//   captures read data, and returns a one-cycle response to the owner.
//   An address above LAST_ADDR completes with an error and never reaches
//   memory.
//
// Ports
//   clk, rst                      rising-edge clock, synchronous active-high reset
//   {nn,cal}_req_valid/ready      request handshake (ready is combinational)
//   {nn,cal}_req_write/addr/wdata request contents, sampled only at accept
//   {nn,cal}_rsp_valid/err/rdata  registered completion pulse, error flag, read record
//   mem_read/write/addr/wdata     registered strobes and payload to the SRAM controller
//   mem_rdata                     read record, valid at the end of the last read cycle
module sram_arbiter #(
  parameter int AW        = 12,
  parameter int DW        = 65,
  parameter int RD_LAT    = 2,
  parameter int WR_CYC    = 1,
  parameter int LAST_ADDR = 60
) (
  input  logic          clk,
  input  logic          rst,
  // port 0: trainer
  input  logic          nn_req_valid,
  output logic          nn_req_ready,
  input  logic          nn_req_write,
  input  logic [AW-1:0] nn_req_addr,
  input  logic [DW-1:0] nn_req_wdata,
  output logic          nn_rsp_valid,
  output logic          nn_rsp_err,
  output logic [DW-1:0] nn_rsp_rdata,
  // port 1: calibrator / logger
  input  logic          cal_req_valid,
  output logic          cal_req_ready,
  input  logic          cal_req_write,
  input  logic [AW-1:0] cal_req_addr,
  input  logic [DW-1:0] cal_req_wdata,
  output logic          cal_rsp_valid,
  output logic          cal_rsp_err,
  output logic [DW-1:0] cal_rsp_rdata,
  // SRAM controller
  output logic          mem_read,
  output logic          mem_write,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE, RD, WR, RESP} state_t;

  localparam logic [3:0]    RD_END   = 4'(RD_LAT - 1);
  localparam logic [3:0]    WR_END   = 4'(WR_CYC - 1);
  localparam logic [AW-1:0] ADDR_MAX = AW'(LAST_ADDR);

  state_t        r_state, w_state_next;
  logic [3:0]    r_cnt;
  logic          r_last_grant;   // 0 = nn, 1 = cal
  logic          r_owner;        // 0 = nn, 1 = cal
  logic [AW-1:0] r_addr;
  logic [DW-1:0] r_wdata;

  logic          r_mem_read, r_mem_write;
  logic [AW-1:0] r_mem_addr;
  logic [DW-1:0] r_mem_wdata;
  logic          r_nn_rsp_valid, r_nn_rsp_err;
  logic          r_cal_rsp_valid, r_cal_rsp_err;
  logic [DW-1:0] r_nn_rsp_rdata, r_cal_rsp_rdata;

  logic          w_grant_nn, w_grant_cal, w_accept;
  logic          w_req_write, w_req_err;
  logic [AW-1:0] w_req_addr;
  logic [DW-1:0] w_req_wdata;
  logic          w_owner_next, w_err_next, w_last_cycle;
  logic          w_strobe_next;

  // A lone requester always wins. On a tie, the port that was not granted
  // last wins.
  assign w_grant_nn  = (r_state == IDLE) && nn_req_valid  && (!cal_req_valid || r_last_grant);
  assign w_grant_cal = (r_state == IDLE) && cal_req_valid && (!nn_req_valid  || !r_last_grant);
  assign w_accept    = w_grant_nn || w_grant_cal;

  assign nn_req_ready  = w_grant_nn;
  assign cal_req_ready = w_grant_cal;

  assign w_req_write = w_grant_cal ? cal_req_write : nn_req_write;
  assign w_req_addr  = w_grant_cal ? cal_req_addr  : nn_req_addr;
  assign w_req_wdata = w_grant_cal ? cal_req_wdata : nn_req_wdata;
  assign w_req_err   = w_req_addr > ADDR_MAX;

  // An error can only come from the IDLE -> RESP shortcut, so it never
  // needs to be stored.
  assign w_owner_next  = w_accept ? w_grant_cal : r_owner;
  assign w_err_next    = w_accept && w_req_err;
  assign w_strobe_next = (w_state_next == RD) || (w_state_next == WR);

  // NOTE: every signal assigned in always_comb gets a default first;
  // otherwise a path that skips an assignment infers a latch.
  always_comb begin
    w_state_next = r_state;
    w_last_cycle = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          if (w_req_err)        w_state_next = RESP;
          else if (w_req_write) w_state_next = WR;
          else                  w_state_next = RD;
        end
      end
      RD: begin
        if (r_cnt == RD_END) begin
          w_last_cycle = 1'b1;
          w_state_next = RESP;
        end
      end
      WR: begin
        if (r_cnt == WR_END) begin
          w_last_cycle = 1'b1;
          w_state_next = RESP;
        end
      end
      RESP:    w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  // State, request capture and all registered outputs. Outputs are loaded
  // from the next state so that they line up with the state they belong to.
  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state         <= IDLE;
      r_cnt           <= '0;
      r_last_grant    <= 1'b1;
      r_owner         <= 1'b0;
      r_addr          <= '0;
      r_wdata         <= '0;
      r_mem_read      <= 1'b0;
      r_mem_write     <= 1'b0;
      r_mem_addr      <= '0;
      r_mem_wdata     <= '0;
      r_nn_rsp_valid  <= 1'b0;
      r_nn_rsp_err    <= 1'b0;
      r_cal_rsp_valid <= 1'b0;
      r_cal_rsp_err   <= 1'b0;
      r_nn_rsp_rdata  <= '0;
      r_cal_rsp_rdata <= '0;
    end else begin
      r_state <= w_state_next;

      if (w_accept) begin
        r_owner      <= w_grant_cal;
        r_last_grant <= w_grant_cal;
        r_addr       <= w_req_addr;
        r_wdata      <= w_req_wdata;
        r_cnt        <= '0;
      end else if (r_state == RD || r_state == WR) begin
        r_cnt <= w_last_cycle ? 4'd0 : r_cnt + 4'd1;
      end

      // On the accept edge the request registers are not loaded yet, so the
      // payload comes straight from the winning port.
      r_mem_read  <= (w_state_next == RD);
      r_mem_write <= (w_state_next == WR);
      r_mem_addr  <= w_strobe_next ? (w_accept ? w_req_addr : r_addr) : '0;
      r_mem_wdata <= (w_state_next == WR) ? (w_accept ? w_req_wdata : r_wdata) : '0;

      r_nn_rsp_valid  <= (w_state_next == RESP) && !w_owner_next;
      r_nn_rsp_err    <= (w_state_next == RESP) && !w_owner_next && w_err_next;
      r_cal_rsp_valid <= (w_state_next == RESP) &&  w_owner_next;
      r_cal_rsp_err   <= (w_state_next == RESP) &&  w_owner_next && w_err_next;

      // The read data is valid at the end of the last held read cycle.
      if (r_state == RD && w_last_cycle) begin
        if (r_owner) r_cal_rsp_rdata <= mem_rdata;
        else         r_nn_rsp_rdata  <= mem_rdata;
      end
    end
  end

  assign mem_read      = r_mem_read;
  assign mem_write     = r_mem_write;
  assign mem_addr      = r_mem_addr;
  assign mem_wdata     = r_mem_wdata;
  assign nn_rsp_valid  = r_nn_rsp_valid;
  assign nn_rsp_err    = r_nn_rsp_err;
  assign nn_rsp_rdata  = r_nn_rsp_rdata;
  assign cal_rsp_valid = r_cal_rsp_valid;
  assign cal_rsp_err   = r_cal_rsp_err;
  assign cal_rsp_rdata = r_cal_rsp_rdata;

endmodule

// File: tb/tb_sram_arbiter.sv
// tb_sram_arbiter
//   Self-checking bench for sram_arbiter, built with the default parameters.
//   Expected responses go into a scoreboard queue when a request is
//   accepted. A negedge monitor pops each entry when a response appears and
//   compares the port, arrival cycle, error flag and read record. Each test
//   task checks strobes and handshakes inline.
module tb_sram_arbiter;
  localparam int AW        = 12;
  localparam int DW        = 65;
  localparam int RD_LAT    = 2;
  localparam int WR_CYC    = 1;
  localparam int LAST_ADDR = 60;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          nn_req_valid = 1'b0, nn_req_write = 1'b0;
  logic [AW-1:0] nn_req_addr = '0;
  logic [DW-1:0] nn_req_wdata = '0;
  logic          cal_req_valid = 1'b0, cal_req_write = 1'b0;
  logic [AW-1:0] cal_req_addr = '0;
  logic [DW-1:0] cal_req_wdata = '0;
  logic          nn_req_ready, cal_req_ready;
  logic          nn_rsp_valid, nn_rsp_err, cal_rsp_valid, cal_rsp_err;
  logic [DW-1:0] nn_rsp_rdata, cal_rsp_rdata;
  logic          mem_read, mem_write;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;

  logic          auto_rd = 1'b0;
  logic [DW-1:0] tb_rdata = '0;

  int n_total = 0;
  int n_bad   = 0;
  int cyc_n   = 0;

  typedef struct {
    bit            port;   // 0 = nn, 1 = cal
    bit            err;
    bit            is_rd;
    logic [DW-1:0] rdata;
    int            due;
  } exp_t;

  exp_t          exp_q[$];
  logic [DW-1:0] shadow [2];   // last read record each port should show

  sram_arbiter #(
    .AW(AW), .DW(DW), .RD_LAT(RD_LAT), .WR_CYC(WR_CYC), .LAST_ADDR(LAST_ADDR)
  ) dut (
    .clk(clk), .rst(rst),
    .nn_req_valid(nn_req_valid), .nn_req_ready(nn_req_ready),
    .nn_req_write(nn_req_write), .nn_req_addr(nn_req_addr), .nn_req_wdata(nn_req_wdata),
    .nn_rsp_valid(nn_rsp_valid), .nn_rsp_err(nn_rsp_err), .nn_rsp_rdata(nn_rsp_rdata),
    .cal_req_valid(cal_req_valid), .cal_req_ready(cal_req_ready),
    .cal_req_write(cal_req_write), .cal_req_addr(cal_req_addr), .cal_req_wdata(cal_req_wdata),
    .cal_rsp_valid(cal_rsp_valid), .cal_rsp_err(cal_rsp_err), .cal_rsp_rdata(cal_rsp_rdata),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc_n++;

  // Address-dependent read record. A read that uses the wrong address
  // therefore returns visibly wrong data.
  function automatic logic [DW-1:0] rd_pat(input logic [AW-1:0] a);
    return {1'b1, 32'hC0DE_0000 | 32'(a), 20'hABCDE, a};
  endfunction

  assign mem_rdata = auto_rd ? rd_pat(mem_addr) : tb_rdata;

  // Scoreboard monitor, sampled mid-cycle.
  exp_t          mon_e;
  bit            mon_port;
  logic          mon_err;
  logic [DW-1:0] mon_rdata, mon_exp;
  always @(negedge clk) begin
    if (rst === 1'b0) begin
      n_total++;
      if ((nn_rsp_valid && cal_rsp_valid) !== 1'b0) begin
        n_bad++;
        $display("FAIL both_rsp_valid cyc=%0d nn=%b cal=%b want at most one", cyc_n, nn_rsp_valid, cal_rsp_valid);
      end
      n_total++;
      if ((mem_read && mem_write) !== 1'b0) begin
        n_bad++;
        $display("FAIL rd_wr_overlap cyc=%0d read=%b write=%b", cyc_n, mem_read, mem_write);
      end
      if (nn_rsp_valid === 1'b1 || cal_rsp_valid === 1'b1) begin
        mon_port  = (cal_rsp_valid === 1'b1);
        mon_err   = mon_port ? cal_rsp_err   : nn_rsp_err;
        mon_rdata = mon_port ? cal_rsp_rdata : nn_rsp_rdata;
        n_total++;
        if (exp_q.size() == 0) begin
          n_bad++;
          $display("FAIL unexpected_rsp cyc=%0d port=%0d, no response expected", cyc_n, mon_port);
        end else begin
          mon_e   = exp_q.pop_front();
          mon_exp = mon_e.is_rd ? mon_e.rdata : shadow[mon_e.port];
          if (mon_port !== mon_e.port || cyc_n != mon_e.due || mon_err !== mon_e.err || mon_rdata !== mon_exp) begin
            n_bad++;
            $display("FAIL rsp cyc=%0d port=%0d err=%b rdata=%h want cyc=%0d port=%0d err=%b rdata=%h",
                     cyc_n, mon_port, mon_err, mon_rdata, mon_e.due, mon_e.port, mon_e.err, mon_exp);
          end
          if (mon_e.is_rd) shadow[mon_e.port] = mon_e.rdata;
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_nn(input logic v, input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
    nn_req_valid = v; nn_req_write = wr; nn_req_addr = a; nn_req_wdata = d;
  endtask

  task automatic drive_cal(input logic v, input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
    cal_req_valid = v; cal_req_write = wr; cal_req_addr = a; cal_req_wdata = d;
  endtask

  task automatic apply_reset();
    exp_q.delete();
    drive_nn(1'b0, 1'b0, '0, '0);
    drive_cal(1'b0, 1'b0, '0, '0);
    rst = 1'b1;
    step(); step();
    rst = 1'b0;
    shadow[0] = '0;
    shadow[1] = '0;
  endtask

  task automatic test_reset();
    apply_reset();
    #1;
    n_total++;
    if ({mem_read, mem_write, mem_addr, mem_wdata} !== '0) begin
      n_bad++;
      $display("FAIL reset_mem read=%b write=%b addr=%0d wdata=%h want all 0", mem_read, mem_write, mem_addr, mem_wdata);
    end
    n_total++;
    if ({nn_rsp_valid, nn_rsp_err, cal_rsp_valid, cal_rsp_err, nn_rsp_rdata, cal_rsp_rdata} !== '0) begin
      n_bad++;
      $display("FAIL reset_rsp nn v/e=%b%b rd=%h cal v/e=%b%b rd=%h want all 0",
               nn_rsp_valid, nn_rsp_err, nn_rsp_rdata, cal_rsp_valid, cal_rsp_err, cal_rsp_rdata);
    end
  endtask

  task automatic test_read_basic();
    logic [DW-1:0] data;
    int t;
    data = 65'h1_2345_6789_ABCD_EF01;
    auto_rd = 1'b0;
    tb_rdata = '0;
    step();
    drive_cal(1'b1, 1'b0, 12'd5, '0);
    #1;
    t = cyc_n;
    n_total++;
    if (cal_req_ready !== 1'b1 || nn_req_ready !== 1'b0) begin
      n_bad++;
      $display("FAIL rd_ready cal=%b nn=%b want cal=1 nn=0", cal_req_ready, nn_req_ready);
    end
    exp_q.push_back('{port: 1'b1, err: 1'b0, is_rd: 1'b1, rdata: data, due: t + RD_LAT + 1});
    step();                         // T+1
    drive_cal(1'b0, 1'b0, '0, '0);
    tb_rdata = 65'h0_DEAD_BEEF_0000_0000;  // wrong data; must not be captured
    #1;
    n_total++;
    if (mem_read !== 1'b1 || mem_write !== 1'b0 || mem_addr !== 12'd5) begin
      n_bad++;
      $display("FAIL rd_strobe_t1 read=%b write=%b addr=%0d want 1 0 5", mem_read, mem_write, mem_addr);
    end
    step();                         // T+2
    tb_rdata = data;
    #1;
    n_total++;
    if (mem_read !== 1'b1 || mem_addr !== 12'd5) begin
      n_bad++;
      $display("FAIL rd_strobe_t2 read=%b addr=%0d want 1 5", mem_read, mem_addr);
    end
    step();                         // T+3
    tb_rdata = '0;
    #1;
    n_total++;
    if (mem_read !== 1'b0 || mem_addr !== 12'd0) begin
      n_bad++;
      $display("FAIL rd_strobe_end read=%b addr=%0d want 0 0", mem_read, mem_addr);
    end
    repeat (2) step();
  endtask

  task automatic test_write();
    logic [DW-1:0] w;
    int t;
    w = {7'hA, 7'hB, 7'hC, 7'hD, 14'h9A, 14'h9B, 1'b1, 8'h12};
    drive_nn(1'b1, 1'b1, 12'd30, w);
    #1;
    t = cyc_n;
    n_total++;
    if (nn_req_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL wr_ready got=%b want=1", nn_req_ready);
    end
    exp_q.push_back('{port: 1'b0, err: 1'b0, is_rd: 1'b0, rdata: '0, due: t + WR_CYC + 1});
    step();                         // T+1
    drive_nn(1'b0, 1'b0, '0, '0);
    #1;
    n_total++;
    if (mem_write !== 1'b1 || mem_read !== 1'b0 || mem_addr !== 12'd30 || mem_wdata !== w) begin
      n_bad++;
      $display("FAIL wr_strobe write=%b read=%b addr=%0d wdata=%h want 1 0 30 %h", mem_write, mem_read, mem_addr, mem_wdata, w);
    end
    step();                         // T+2
    #1;
    n_total++;
    if (mem_write !== 1'b0 || mem_wdata !== '0) begin
      n_bad++;
      $display("FAIL wr_strobe_end write=%b wdata=%h want 0 0", mem_write, mem_wdata);
    end
    repeat (2) step();
  endtask

  task automatic test_addr_error();
    int t;
    auto_rd = 1'b1;
    // highest legal address reads normally
    drive_cal(1'b1, 1'b0, 12'(LAST_ADDR), '0);
    #1;
    t = cyc_n;
    n_total++;
    if (cal_req_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL last_addr_ready got=%b want=1", cal_req_ready);
    end
    exp_q.push_back('{port: 1'b1, err: 1'b0, is_rd: 1'b1, rdata: rd_pat(12'(LAST_ADDR)), due: t + RD_LAT + 1});
    step();
    drive_cal(1'b0, 1'b0, '0, '0);
    repeat (RD_LAT + 1) step();
    // one past the end: error, no strobe, rdata retained
    drive_cal(1'b1, 1'b0, 12'(LAST_ADDR + 1), '0);
    #1;
    t = cyc_n;
    n_total++;
    if (cal_req_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL err_ready got=%b want=1", cal_req_ready);
    end
    exp_q.push_back('{port: 1'b1, err: 1'b1, is_rd: 1'b0, rdata: '0, due: t + 1});
    step();                         // T+1
    drive_cal(1'b0, 1'b0, '0, '0);
    #1;
    n_total++;
    if (mem_read !== 1'b0 || mem_write !== 1'b0) begin
      n_bad++;
      $display("FAIL err_no_strobe read=%b write=%b want 0 0", mem_read, mem_write);
    end
    step();                         // T+2
    #1;
    n_total++;
    if (mem_read !== 1'b0 || mem_write !== 1'b0) begin
      n_bad++;
      $display("FAIL err_no_strobe2 read=%b write=%b want 0 0", mem_read, mem_write);
    end
    repeat (2) step();
  endtask

  task automatic test_hold_inputs();
    int t;
    auto_rd = 1'b1;
    drive_nn(1'b1, 1'b0, 12'd4, '0);
    #1;
    t = cyc_n;
    n_total++;
    if (nn_req_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL hold_ready got=%b want=1", nn_req_ready);
    end
    exp_q.push_back('{port: 1'b0, err: 1'b0, is_rd: 1'b1, rdata: rd_pat(12'd4), due: t + RD_LAT + 1});
    for (int k = 1; k <= RD_LAT; k++) begin
      step();
      drive_nn(1'b0, 1'b1, 12'd16, '1);
      #1;
      n_total++;
      if (mem_read !== 1'b1 || mem_addr !== 12'd4) begin
        n_bad++;
        $display("FAIL hold_addr T+%0d read=%b addr=%0d want 1 4", k, mem_read, mem_addr);
      end
    end
    drive_nn(1'b0, 1'b0, '0, '0);
    repeat (3) step();
  endtask

  task automatic test_reset_mid();
    int t;
    apply_reset();
    auto_rd = 1'b1;
    drive_nn(1'b1, 1'b0, 12'd7, '0);   // this read is dropped by the reset
    #1;
    n_total++;
    if (nn_req_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL mid_ready got=%b want=1", nn_req_ready);
    end
    step();                         // T+1
    drive_nn(1'b0, 1'b0, '0, '0);
    rst = 1'b1;
    #1;
    n_total++;
    if (mem_read !== 1'b1) begin
      n_bad++;
      $display("FAIL mid_strobe read=%b want=1", mem_read);
    end
    step();                         // T+2, first cycle after the reset edge
    rst = 1'b0;
    drive_nn(1'b1, 1'b0, 12'd8, '0);
    drive_cal(1'b1, 1'b0, 12'd9, '0);
    #1;
    t = cyc_n;
    n_total++;
    if ({mem_read, mem_write, mem_addr, mem_wdata, nn_rsp_valid, nn_rsp_err, cal_rsp_valid, cal_rsp_err,
         nn_rsp_rdata, cal_rsp_rdata} !== '0) begin
      n_bad++;
      $display("FAIL mid_reset_outputs mem r/w=%b%b addr=%0d rsp nn=%b%b cal=%b%b want all 0",
               mem_read, mem_write, mem_addr, nn_rsp_valid, nn_rsp_err, cal_rsp_valid, cal_rsp_err);
    end
    n_total++;
    if (nn_req_ready !== 1'b1 || cal_req_ready !== 1'b0) begin
      n_bad++;
      $display("FAIL mid_tie_grant nn=%b cal=%b want nn=1 cal=0", nn_req_ready, cal_req_ready);
    end
    exp_q.push_back('{port: 1'b0, err: 1'b0, is_rd: 1'b1, rdata: rd_pat(12'd8), due: t + RD_LAT + 1});
    step();
    drive_nn(1'b0, 1'b0, '0, '0);
    drive_cal(1'b0, 1'b0, '0, '0);
    repeat (5) step();
  endtask

  task automatic test_round_robin();
    int  grants;
    bit  p;
    apply_reset();
    auto_rd = 1'b1;
    grants = 0;
    drive_nn(1'b1, 1'b0, 12'd10, '0);
    drive_cal(1'b1, 1'b0, 12'd20, '0);
    for (int c = 0; c < 60 && grants < 4; c++) begin
      #1;
      if (nn_req_ready === 1'b1 || cal_req_ready === 1'b1) begin
        p = (cal_req_ready === 1'b1);
        n_total++;
        if ((nn_req_ready && cal_req_ready) || p != grants[0]) begin
          n_bad++;
          $display("FAIL rr_grant%0d nn=%b cal=%b want port %0d", grants, nn_req_ready, cal_req_ready, grants[0]);
        end
        exp_q.push_back('{port: p, err: 1'b0, is_rd: 1'b1, rdata: rd_pat(p ? 12'd20 : 12'd10), due: cyc_n + RD_LAT + 1});
        grants++;
      end
      step();
    end
    drive_nn(1'b0, 1'b0, '0, '0);
    drive_cal(1'b0, 1'b0, '0, '0);
    n_total++;
    if (grants != 4) begin
      n_bad++;
      $display("FAIL rr_timeout grants=%0d want=4", grants);
    end
    repeat (RD_LAT + 3) step();
  endtask

  initial begin
    shadow[0] = '0;
    shadow[1] = '0;
    test_reset();
    test_read_basic();
    test_write();
    test_addr_error();
    test_hold_inputs();
    test_reset_mid();
    test_round_robin();
    repeat (3) step();
    n_total++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL missing_rsp outstanding=%0d want=0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
